crc_arbiter: RTL and testbench
==============================

# crc_arbiter

Shares one `crc_calculate` engine between the transmit framer (`udpip_tx`) and the receive checker (`udpip_rx`). It latches start pulses from both requesters and grants the engine round-robin. It launches each job, watches for completion with a watchdog, and returns results. A TX job returns the computed CRC. An RX job returns a pass/fail compare against the received CRC.

## Interface
- `TIMEOUT`, default 1023: engine cycles allowed per job before abort. Range 1..65535.
- `DATA_W`, default 480: engine data width; ceiling must be < `DATA_W`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `tx_crc_start`  in  1  one-cycle TX job request.
- `tx_crc_input`  in  DATA_W  TX data; held stable by requester until `tx_crc_valid`.
- `tx_crc_ceiling`  in  16  TX last bit index; held stable likewise.
- `tx_crc_valid`  out  1  one-cycle TX completion pulse.
- `tx_calculated_crc`  out  32  TX result; holds until next TX completion.
- `tx_crc_err`  out  1  qualifies `tx_crc_valid`: timeout or bad ceiling.
- `rx_crc_start`  in  1  one-cycle RX job request.
- `rx_crc_in`  in  DATA_W  RX data; held stable until `rx_crc_check`.
- `rx_crc_ceiling`  in  16  RX last bit index.
- `rx_received_crc`  in  32  CRC to compare against.
- `rx_crc_check`  out  1  one-cycle RX completion pulse.
- `rx_crc_valid`  out  1  CRC match; meaningful with `rx_crc_check`, holds until next RX completion.
- `eng_data`  out  DATA_W  engine data mux output, driven from the granted requester.
- `eng_ceiling`  out  16  engine ceiling mux output.
- `eng_start`  out  1  one-cycle engine start.
- `eng_crc`  in  32  engine result.
- `eng_done`  in  1  engine completion (`check_valid`); sampled only in BUSY.
- `busy`  out  1  high in LAUNCH, BUSY and RESP.

## Operation
- Each requester has a pending flag. A start pulse sets the flag.
- A start pulse is ignored while that requester's job is pending or in flight. No queuing deeper than 1.
- FSM states:
  - IDLE: if any pending, choose a grant and go to LAUNCH.
  - LAUNCH: drive `eng_start`=1 for exactly one cycle, load watchdog = `TIMEOUT`, go to BUSY.
  - BUSY: on `eng_done` capture `eng_crc` and go to RESP. If the watchdog reaches 0, go to RESP with abort set. Otherwise decrement the watchdog.
  - RESP: pulse the granted requester's completion, clear its pending flag, update `last_grant`, return to IDLE.
- Arbitration: only one pending requester → grant it. Both pending → grant the one not equal to `last_grant`. `last_grant` resets to RX, so the first tie goes to TX.
- `eng_data` and `eng_ceiling` follow the grant register from LAUNCH through RESP. In IDLE they are driven from TX with `eng_start`=0.
- Ceiling check happens at grant. A ceiling ≥ `DATA_W` skips the engine: IDLE→RESP directly with error.
- TX result:
  - Normal completion: `tx_calculated_crc` = captured CRC, `tx_crc_err`=0.
  - Abort or bad ceiling: `tx_calculated_crc`=0, `tx_crc_err`=1.
- RX result:
  - Normal completion: `rx_crc_valid` = (captured CRC == `rx_received_crc`), 32-bit exact compare.
  - Abort or bad ceiling: `rx_crc_valid`=0.
- A start pulse in the same cycle its own completion pulses is accepted as a new job.
- Reset values, all outputs:
  - 0: `tx_crc_valid`, `tx_calculated_crc`, `tx_crc_err`, `rx_crc_check`, `rx_crc_valid`, `eng_start`, `eng_ceiling`, `eng_data`, `busy`.
  - Internal state after reset: FSM=IDLE, pending flags=0, `last_grant`=RX.
- Reset mid-job drops the job. No completion pulse is issued for it. A late `eng_done` arriving after reset is ignored, because it is sampled only in BUSY.

## Timing
- Start pulse sampled at edge N sets pending.
- IDLE→LAUNCH at N+1; `eng_start` high during cycle N+1..N+2.
- BUSY entered at N+2.
- If `eng_done` is sampled high at edge M, completion pulses during cycle M..M+1.
- Arbiter overhead: 2 cycles before engine start, 1 cycle after done.
- Back-to-back jobs: next `eng_start` asserts 2 cycles after the previous completion pulse.
- Watchdog: abort completion pulses `TIMEOUT`+1 cycles after BUSY entry if `eng_done` never arrives.
- Bad ceiling: completion pulses 2 cycles after the start edge; `eng_start` never asserts.
- All outputs registered.

## Test plan
- TX job:
  - Stimulus: data 304'd0 concatenated with 176'h4c82ae9bf314c82ae9bf314c82ae9bf314c82ae9bf31, ceiling 175, engine model returns 32'h18639996.
  - Required: one `eng_start` pulse; `tx_crc_valid` one cycle with `tx_calculated_crc`=32'h18639996, `tx_crc_err`=0.
- RX match/mismatch:
  - Stimulus: same data, `rx_received_crc`=32'h18639996, then 32'h98639996.
  - Required: `rx_crc_check` pulses twice, with `rx_crc_valid`=1 then 0.
- Simultaneous starts from reset:
  - Required: TX granted first; RX `eng_start` 2 cycles after the TX completion.
  - Repeat tie: RX is now `last_grant`, so TX wins again. Next tie after an RX-only job: TX. After a TX job: RX.
- Timeout, with `TIMEOUT`=8 and the engine never asserting done:
  - Required: completion 9 cycles after BUSY entry, `tx_crc_err`=1, `tx_calculated_crc`=0; the RX case gives `rx_crc_valid`=0.
- Bad ceiling 480:
  - Required: no `eng_start`; error completion 2 cycles after the start edge.
- Reset mid-BUSY, followed by a stale `eng_done`:
  - Required: no completion pulses; all outputs 0; a fresh TX start afterwards completes normally.

Source files
------------

// File: rtl/crc_arbiter.sv
// ---------------------------------------------------------------------------
// crc_arbiter
//
// Shares one crc_calculate engine between the transmit framer (TX) and the
// receive checker (RX). Start pulses are latched into one pending flag per
// requester. The engine is granted round-robin, and each job is launched and
// guarded by a watchdog. A TX job returns the computed CRC. An RX job returns
// a pass/fail compare against the received CRC.
//
// Parameters
//   TIMEOUT  engine cycles allowed per job before abort (1..65535)
//   DATA_W   engine data width; a ceiling >= DATA_W is rejected
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   tx_crc_start        one-cycle TX job request
//   tx_crc_input        TX data, held by requester until tx_crc_valid
//   tx_crc_ceiling      TX last bit index
//   tx_crc_valid        one-cycle TX completion pulse
//   tx_calculated_crc   TX result, held until next TX completion
//   tx_crc_err          qualifies tx_crc_valid: timeout or bad ceiling
//   rx_crc_start        one-cycle RX job request
//   rx_crc_in           RX data, held by requester until rx_crc_check
//   rx_crc_ceiling      RX last bit index
//   rx_received_crc     CRC the RX result is compared against
//   rx_crc_check        one-cycle RX completion pulse
//   rx_crc_valid        CRC match, held until next RX completion
//   eng_data            engine data, muxed from the granted requester
//   eng_ceiling         engine ceiling, muxed from the granted requester
//   eng_start           one-cycle engine start
//   eng_crc             engine result
//   eng_done            engine completion, only sampled while BUSY
//   busy                high in LAUNCH, BUSY and RESP
// ---------------------------------------------------------------------------
module crc_arbiter #(
    parameter int TIMEOUT = 1023,
    parameter int DATA_W  = 480
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              tx_crc_start,
    input  logic [DATA_W-1:0] tx_crc_input,
    input  logic [15:0]       tx_crc_ceiling,
    output logic              tx_crc_valid,
    output logic [31:0]       tx_calculated_crc,
    output logic              tx_crc_err,

    input  logic              rx_crc_start,
    input  logic [DATA_W-1:0] rx_crc_in,
    input  logic [15:0]       rx_crc_ceiling,
    input  logic [31:0]       rx_received_crc,
    output logic              rx_crc_check,
    output logic              rx_crc_valid,

    output logic [DATA_W-1:0] eng_data,
    output logic [15:0]       eng_ceiling,
    output logic              eng_start,
    input  logic [31:0]       eng_crc,
    input  logic              eng_done,

    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_RESP
    } state_t;

    typedef enum logic {
        REQ_TX = 1'b0,
        REQ_RX = 1'b1
    } req_t;

    localparam logic [15:0] WD_LOAD    = 16'(TIMEOUT);
    localparam logic [16:0] CEIL_LIMIT = 17'(DATA_W);

    state_t      state, state_d;
    req_t        grant, grant_d;
    req_t        last_grant;
    logic        tx_pending, rx_pending;
    logic [15:0] wd, wd_d;
    logic [15:0] sel_ceiling;
    logic        job_ok;
    logic        enter_resp;
    logic        resp_tx, resp_rx;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a default before the case statement, so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state;
        grant_d     = grant;
        wd_d        = wd;
        job_ok      = 1'b0;
        sel_ceiling = tx_crc_ceiling;

        case (state)
            S_IDLE: begin
                if (tx_pending || rx_pending) begin
                    if (tx_pending && rx_pending)
                        grant_d = (last_grant == REQ_TX) ? REQ_RX : REQ_TX;
                    else if (tx_pending)
                        grant_d = REQ_TX;
                    else
                        grant_d = REQ_RX;

                    sel_ceiling = (grant_d == REQ_TX) ? tx_crc_ceiling : rx_crc_ceiling;
                    // An out-of-range ceiling never reaches the engine.
                    state_d = ({1'b0, sel_ceiling} >= CEIL_LIMIT) ? S_RESP : S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                wd_d    = WD_LOAD;
                state_d = S_BUSY;
            end

            S_BUSY: begin
                if (eng_done) begin
                    job_ok  = 1'b1;
                    state_d = S_RESP;
                end else if (wd == 16'd0) begin
                    state_d = S_RESP;  // watchdog abort, job_ok stays 0
                end else begin
                    wd_d = wd - 16'd1;
                end
            end

            S_RESP: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // Results are registered on the edge that enters RESP. The completion
    // pulse therefore coincides with the RESP cycle.
    assign enter_resp = (state_d == S_RESP) && (state != S_RESP);
    assign resp_tx    = (state == S_RESP) && (grant == REQ_TX);
    assign resp_rx    = (state == S_RESP) && (grant == REQ_RX);

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then see pre-edge values, whatever the order of the statements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            grant      <= REQ_TX;
            last_grant <= REQ_RX;
            wd         <= 16'd0;
            tx_pending <= 1'b0;
            rx_pending <= 1'b0;
        end else begin
            state <= state_d;
            grant <= grant_d;
            wd    <= wd_d;
            if (state == S_RESP)
                last_grant <= grant;
            // A start pulse sets the flag. A set flag already covers a
            // duplicate start, and a start during the job's own RESP
            // overrides the clear so that it becomes the next job.
            tx_pending <= tx_crc_start | (tx_pending & ~resp_tx);
            rx_pending <= rx_crc_start | (rx_pending & ~resp_rx);
        end
    end

    // -----------------------------------------------------------------------
    // Registered outputs
    // -----------------------------------------------------------------------
    // NOTE: the wide eng_data register is reset too, because every output
    // must read 0 while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_crc_valid      <= 1'b0;
            tx_calculated_crc <= 32'd0;
            tx_crc_err        <= 1'b0;
            rx_crc_check      <= 1'b0;
            rx_crc_valid      <= 1'b0;
            eng_start         <= 1'b0;
            eng_ceiling       <= 16'd0;
            eng_data          <= '0;
            busy              <= 1'b0;
        end else begin
            tx_crc_valid <= enter_resp && (grant_d == REQ_TX);
            rx_crc_check <= enter_resp && (grant_d == REQ_RX);

            if (enter_resp && (grant_d == REQ_TX)) begin
                tx_calculated_crc <= job_ok ? eng_crc : 32'd0;
                tx_crc_err        <= ~job_ok;
            end
            if (enter_resp && (grant_d == REQ_RX))
                rx_crc_valid <= job_ok && (eng_crc == rx_received_crc);

            eng_start <= (state_d == S_LAUNCH);
            busy      <= (state_d != S_IDLE);

            // The mux defaults to TX while idle and follows the grant
            // from LAUNCH through RESP.
            if ((state_d == S_IDLE) || (grant_d == REQ_TX)) begin
                eng_data    <= tx_crc_input;
                eng_ceiling <= tx_crc_ceiling;
            end else begin
                eng_data    <= rx_crc_in;
                eng_ceiling <= rx_crc_ceiling;
            end
        end
    end

endmodule

// File: tb/tb_crc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_crc_arbiter
//
// Self-checking bench for crc_arbiter. A behavioural engine answers
// eng_start after a programmable latency. A monitor logs every engine launch
// and every completion pulse. The directed sequence pushes the expected
// launches and results into queues and pops them against the logged events.
// ---------------------------------------------------------------------------
module tb_crc_arbiter;

    localparam int TIMEOUT = 8;
    localparam int DATA_W  = 480;
    localparam int LOG_N   = 64;

    typedef struct {
        logic        is_tx;
        logic [31:0] crc;
        logic        err;
        logic        valid;
    } exp_t;

    typedef struct {
        logic [15:0]       ceil;
        logic [DATA_W-1:0] data;
    } exp_st_t;

    typedef struct {
        int          cyc;
        logic        is_tx;
        logic        both;
        logic [31:0] crc;
        logic        err;
        logic        valid;
    } got_t;

    typedef struct {
        int                cyc;
        logic [15:0]       ceil;
        logic [DATA_W-1:0] data;
    } got_st_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tx_crc_start;
    logic [DATA_W-1:0] tx_crc_input;
    logic [15:0]       tx_crc_ceiling;
    logic              tx_crc_valid;
    logic [31:0]       tx_calculated_crc;
    logic              tx_crc_err;
    logic              rx_crc_start;
    logic [DATA_W-1:0] rx_crc_in;
    logic [15:0]       rx_crc_ceiling;
    logic [31:0]       rx_received_crc;
    logic              rx_crc_check;
    logic              rx_crc_valid;
    logic [DATA_W-1:0] eng_data;
    logic [15:0]       eng_ceiling;
    logic              eng_start;
    logic [31:0]       eng_crc;
    logic              eng_done;
    logic              busy;

    crc_arbiter #(.TIMEOUT(TIMEOUT), .DATA_W(DATA_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .tx_crc_start      (tx_crc_start),
        .tx_crc_input      (tx_crc_input),
        .tx_crc_ceiling    (tx_crc_ceiling),
        .tx_crc_valid      (tx_crc_valid),
        .tx_calculated_crc (tx_calculated_crc),
        .tx_crc_err        (tx_crc_err),
        .rx_crc_start      (rx_crc_start),
        .rx_crc_in         (rx_crc_in),
        .rx_crc_ceiling    (rx_crc_ceiling),
        .rx_received_crc   (rx_received_crc),
        .rx_crc_check      (rx_crc_check),
        .rx_crc_valid      (rx_crc_valid),
        .eng_data          (eng_data),
        .eng_ceiling       (eng_ceiling),
        .eng_start         (eng_start),
        .eng_crc           (eng_crc),
        .eng_done          (eng_done),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Engine model: done one cycle wide, 'lat' cycles after eng_start.
    // ------------------------------------------------------------------
    logic        eng_en;
    int          lat;
    logic [31:0] model_crc;
    int          inject_cyc;
    int          eng_cnt = 0;

    initial begin
        eng_done = 1'b0;
        eng_crc  = 32'd0;
    end

    always @(negedge clk) begin
        eng_done <= 1'b0;
        if (eng_start && eng_en) begin
            eng_cnt <= lat;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                eng_done <= 1'b1;
                eng_crc  <= model_crc;
            end
        end
        if (cyc == inject_cyc)
            eng_done <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Monitor: log launches and completion pulses
    // ------------------------------------------------------------------
    got_t    got_arr [LOG_N];
    got_st_t st_arr  [LOG_N];
    int      got_cnt = 0;
    int      st_cnt  = 0;

    always @(negedge clk) begin
        if (eng_start && st_cnt < LOG_N) begin
            st_arr[st_cnt] <= '{cyc, eng_ceiling, eng_data};
            st_cnt <= st_cnt + 1;
        end
        if ((tx_crc_valid || rx_crc_check) && got_cnt < LOG_N) begin
            got_arr[got_cnt] <= '{cyc, tx_crc_valid, tx_crc_valid & rx_crc_check,
                                  tx_calculated_crc, tx_crc_err, rx_crc_valid};
            got_cnt <= got_cnt + 1;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int      n_assert = 0;
    int      n_fail   = 0;
    exp_t    exp_q[$];
    exp_st_t exp_st_q[$];
    int      got_rd = 0;
    int      st_rd  = 0;
    int      last_tx_cyc;
    int      last_rx_cyc;
    int      last_st_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
        end
    endtask

    task automatic check_data(input string tag, input logic [DATA_W-1:0] obs,
                              input logic [DATA_W-1:0] req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic t, input logic r, output int s);
        s            = cyc;
        tx_crc_start = t;
        rx_crc_start = r;
        tick();
        tx_crc_start = 1'b0;
        rx_crc_start = 1'b0;
    endtask

    task automatic expect_job(input logic is_tx, input logic [31:0] crc,
                              input logic err, input logic valid);
        exp_t e;
        e = '{is_tx, crc, err, valid};
        exp_q.push_back(e);
    endtask

    task automatic expect_start(input logic [15:0] ceil, input logic [DATA_W-1:0] data);
        exp_st_t e;
        e = '{ceil, data};
        exp_st_q.push_back(e);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_tx_crc_valid"},      32'(tx_crc_valid), 32'd0);
        check({pfx, "_tx_calculated_crc"}, tx_calculated_crc, 32'd0);
        check({pfx, "_tx_crc_err"},        32'(tx_crc_err),   32'd0);
        check({pfx, "_rx_crc_check"},      32'(rx_crc_check), 32'd0);
        check({pfx, "_rx_crc_valid"},      32'(rx_crc_valid), 32'd0);
        check({pfx, "_eng_start"},         32'(eng_start),    32'd0);
        check({pfx, "_eng_ceiling"},       32'(eng_ceiling),  32'd0);
        check_data({pfx, "_eng_data"},     eng_data,          '0);
        check({pfx, "_busy"},              32'(busy),         32'd0);
    endtask

    // Wait (bounded) for every outstanding completion, then pop and compare
    // both the completion log and the launch log.
    task automatic drain(input int budget);
        int   k;
        exp_t e;
        got_t g;
        exp_st_t es;
        got_st_t gs;
        k = 0;
        while ((got_cnt - got_rd) < exp_q.size() && k < budget) begin
            tick();
            k++;
        end
        check("completion_count", 32'(got_cnt - got_rd), 32'(exp_q.size()));
        tick();
        tick();
        while (got_rd < got_cnt) begin
            g = got_arr[got_rd];
            got_rd++;
            if (exp_q.size() == 0) begin
                check("unexpected_completion", 32'(g.cyc), 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                check("completion_kind", 32'(g.is_tx), 32'(e.is_tx));
                check("both_pulses", 32'(g.both), 32'd0);
                if (e.is_tx) begin
                    check("tx_calculated_crc", g.crc, e.crc);
                    check("tx_crc_err", 32'(g.err), 32'(e.err));
                    last_tx_cyc = g.cyc;
                end else begin
                    check("rx_crc_valid", 32'(g.valid), 32'(e.valid));
                    last_rx_cyc = g.cyc;
                end
            end
        end
        exp_q.delete();
        while (st_rd < st_cnt) begin
            gs = st_arr[st_rd];
            st_rd++;
            if (exp_st_q.size() == 0) begin
                check("unexpected_eng_start", 32'(gs.cyc), 32'hffff_ffff);
            end else begin
                es = exp_st_q.pop_front();
                check("eng_ceiling", 32'(gs.ceil), 32'(es.ceil));
                check_data("eng_data", gs.data, es.data);
                last_st_cyc = gs.cyc;
            end
        end
        check("missing_eng_start", 32'(exp_st_q.size()), 32'd0);
        exp_st_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        logic [DATA_W-1:0] data_a;
        logic [DATA_W-1:0] data_b;
        int s;
        int s2;

        data_a          = {304'd0, 176'h4c82ae9bf314c82ae9bf314c82ae9bf314c82ae9bf31};
        data_b          = {DATA_W{1'b1}} ^ data_a;
        rst_n           = 1'b0;
        tx_crc_start    = 1'b0;
        rx_crc_start    = 1'b0;
        tx_crc_input    = '0;
        tx_crc_ceiling  = 16'd0;
        rx_crc_in       = '0;
        rx_crc_ceiling  = 16'd0;
        rx_received_crc = 32'd0;
        eng_en          = 1'b1;
        lat             = 3;
        model_crc       = 32'h1863_9996;
        inject_cyc      = -1;

        // Reset state
        tick();
        tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // TX job: one launch, normal CRC, fixed latency
        tx_crc_input   = data_a;
        tx_crc_ceiling = 16'd175;
        expect_start(16'd175, data_a);
        expect_job(1'b1, 32'h1863_9996, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, s);
        drain(40);
        check("tx_eng_start_cycle", 32'(last_st_cyc), 32'(s + 2));
        check("tx_completion_cycle", 32'(last_tx_cyc), 32'(s + 3 + lat + 0));
        check("tx_crc_valid_one_cycle", 32'(tx_crc_valid), 32'd0);
        check("tx_crc_held", tx_calculated_crc, 32'h1863_9996);

        // RX match then mismatch
        rx_crc_in       = data_b;
        rx_crc_ceiling  = 16'd175;
        rx_received_crc = 32'h1863_9996;
        expect_start(16'd175, data_b);
        expect_job(1'b0, 32'd0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, s);
        drain(40);
        rx_received_crc = 32'h9863_9996;
        expect_start(16'd175, data_b);
        expect_job(1'b0, 32'd0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, s);
        drain(40);
        check("rx_crc_valid_held", 32'(rx_crc_valid), 32'd0);

        // Simultaneous starts from reset: TX first, RX launched 2 cycles
        // after the TX completion
        do_reset();
        rx_received_crc = 32'h1863_9996;
        rx_crc_ceiling  = 16'd100;
        expect_start(16'd175, data_a);
        expect_start(16'd100, data_b);
        expect_job(1'b1, 32'h1863_9996, 1'b0, 1'b0);
        expect_job(1'b0, 32'd0, 1'b0, 1'b1);
        pulse(1'b1, 1'b1, s);
        drain(60);
        check("tie_rx_start_after_tx_done", 32'(last_st_cyc - last_tx_cyc), 32'd2);

        // Repeat tie: last_grant is RX, so TX wins again
        expect_start(16'd175, data_a);
        expect_start(16'd100, data_b);
        expect_job(1'b1, 32'h1863_9996, 1'b0, 1'b0);
        expect_job(1'b0, 32'd0, 1'b0, 1'b1);
        pulse(1'b1, 1'b1, s);
        drain(60);

        // RX-only job, then tie: TX wins
        expect_start(16'd100, data_b);
        expect_job(1'b0, 32'd0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, s);
        drain(40);
        expect_start(16'd175, data_a);
        expect_start(16'd100, data_b);
        expect_job(1'b1, 32'h1863_9996, 1'b0, 1'b0);
        expect_job(1'b0, 32'd0, 1'b0, 1'b1);
        pulse(1'b1, 1'b1, s);
        drain(60);

        // TX-only job, then tie: RX wins
        expect_start(16'd175, data_a);
        expect_job(1'b1, 32'h1863_9996, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, s);
        drain(40);
        expect_start(16'd100, data_b);
        expect_start(16'd175, data_a);
        expect_job(1'b0, 32'd0, 1'b0, 1'b1);
        expect_job(1'b1, 32'h1863_9996, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, s);
        drain(60);
        check("tie_after_tx_rx_first", 32'(last_rx_cyc < last_tx_cyc), 32'd1);

        // Watchdog abort: engine never answers. eng_crc still holds the
        // last good CRC, so an abort that used it would show up here.
        eng_en = 1'b0;
        expect_start(16'd175, data_a);
        expect_job(1'b1, 32'd0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, s);
        drain(40);
        check("timeout_tx_cycle", 32'(last_tx_cyc), 32'(s + 3 + TIMEOUT + 1));
        expect_start(16'd100, data_b);
        expect_job(1'b0, 32'd0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, s);
        drain(40);
        check("timeout_rx_cycle", 32'(last_rx_cyc), 32'(s + 3 + TIMEOUT + 1));
        eng_en = 1'b1;

        // Bad ceiling: no launch, error completion 2 cycles after start
        tx_crc_ceiling = 16'd480;
        expect_job(1'b1, 32'd0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, s);
        drain(20);
        check("bad_ceiling_tx_cycle", 32'(last_tx_cyc), 32'(s + 2));
        rx_crc_ceiling = 16'd500;
        expect_job(1'b0, 32'd0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, s);
        drain(20);
        check("bad_ceiling_rx_cycle", 32'(last_rx_cyc), 32'(s + 2));
        tx_crc_ceiling = 16'd175;
        rx_crc_ceiling = 16'd100;

        // Reset mid-BUSY, then a stale eng_done: no completion at all
        eng_en = 1'b0;
        expect_start(16'd175, data_a);
        pulse(1'b1, 1'b0, s);
        tick();
        tick();
        tick();
        check("mid_job_busy", 32'(busy), 32'd1);
        drain(0);
        rst_n = 1'b0;
        tick();
        check_outputs_zero("mid_reset");
        inject_cyc = cyc + 2;
        rst_n = 1'b1;
        s2 = got_cnt;
        for (int i = 0; i < 6; i++) tick();
        check("stale_done_no_completion", 32'(got_cnt), 32'(s2));
        check("stale_done_no_launch", 32'(st_cnt), 32'(st_rd));
        check("stale_done_busy", 32'(busy), 32'd0);
        check("stale_done_tx_crc", tx_calculated_crc, 32'd0);
        eng_en = 1'b1;

        // Fresh TX job after the reset completes normally
        model_crc = 32'h0bad_cafe;
        expect_start(16'd175, data_a);
        expect_job(1'b1, 32'h0bad_cafe, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, s);
        drain(40);
        check("fresh_tx_cycle", 32'(last_tx_cyc), 32'(s + 3 + lat));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
